// File: rtl/btn_debounce.sv
// Per-button conditioner: two-flop synchronizer plus debounce FSM per channel, producing a clean
// level and single-cycle press/release pulses.
module btn_debounce #(
   parameter int unsigned NB_BTN          = 4,
   parameter int unsigned NB_DEBOUNCE     = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_BTN-1:0] o_btn_level,
   output logic [NB_BTN-1:0] o_btn_press,
   output logic [NB_BTN-1:0] o_btn_release
);

   typedef enum logic [1:0] {
      StIdle,
      StPressWait,
      StPressed,
      StReleaseWait
   } state_e;

   localparam logic [NB_DEBOUNCE-1:0] CntMax = NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);
   localparam logic [NB_DEBOUNCE-1:0] CntOne = NB_DEBOUNCE'(1);

   for (genvar n = 0; n < NB_BTN; n++) begin : g_chan
      logic                   sync1_q;
      logic                   sync2_q;
      state_e                 state_q;
      logic [NB_DEBOUNCE-1:0] cnt_q;
      logic                   level_q;
      logic                   press_q;
      logic                   release_q;

      // Counter is cleared on every state entry, so it never runs past CntMax.
      always_ff @(posedge clock or negedge i_reset) begin
         if (!i_reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync1_q   <= i_btn[n];
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
               StIdle: begin
                  if (sync2_q) begin
                     state_q <= StPressWait;
                     cnt_q   <= '0;
                  end
               end
               StPressWait: begin
                  if (!sync2_q) begin
                     state_q <= StIdle;
                     cnt_q   <= '0;
                  end else if (cnt_q == CntMax) begin
                     state_q <= StPressed;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     press_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntOne;
                  end
               end
               StPressed: begin
                  if (!sync2_q) begin
                     state_q <= StReleaseWait;
                     cnt_q   <= '0;
                  end
               end
               StReleaseWait: begin
                  if (sync2_q) begin
                     state_q <= StPressed;
                     cnt_q   <= '0;
                  end else if (cnt_q == CntMax) begin
                     state_q   <= StIdle;
                     cnt_q     <= '0;
                     level_q   <= 1'b0;
                     release_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntOne;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end

      assign o_btn_level[n]   = level_q;
      assign o_btn_press[n]   = press_q;
      assign o_btn_release[n] = release_q;
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4: outputs land on the 7th edge after the
// first edge that samples a new stable level.
module tb_btn_debounce;

   localparam int unsigned NbBtn = 4;

   logic             clock;
   logic             i_reset;
   logic [NbBtn-1:0] i_btn;
   logic [NbBtn-1:0] o_btn_level;
   logic [NbBtn-1:0] o_btn_press;
   logic [NbBtn-1:0] o_btn_release;

   int n_vec;
   int n_err;

   btn_debounce #(
      .NB_BTN          (NbBtn),
      .NB_DEBOUNCE     (3),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clock         (clock),
      .i_reset       (i_reset),
      .i_btn         (i_btn),
      .o_btn_level   (o_btn_level),
      .o_btn_press   (o_btn_press),
      .o_btn_release (o_btn_release)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [NbBtn-1:0] got,
                        input logic [NbBtn-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive btn, take one rising edge, then check all three outputs.
   task automatic step(input string tag, input logic [NbBtn-1:0] btn,
                       input logic [NbBtn-1:0] lvl, input logic [NbBtn-1:0] prs,
                       input logic [NbBtn-1:0] rel);
      i_btn = btn;
      @(posedge clock);
      #1;
      check({tag, ".level"}, o_btn_level, lvl);
      check({tag, ".press"}, o_btn_press, prs);
      check({tag, ".release"}, o_btn_release, rel);
   endtask

   // Hold btn for n edges starting from a settled level prev; changed bits flip on edge 7.
   task automatic settle(input string tag, input logic [NbBtn-1:0] btn,
                         input logic [NbBtn-1:0] prev, input int n);
      logic [NbBtn-1:0] chg;
      chg = btn ^ prev;
      for (int e = 1; e <= n; e++) begin
         if (e < 7)       step(tag, btn, prev, '0, '0);
         else if (e == 7) step(tag, btn, btn, chg & btn, chg & ~btn);
         else             step(tag, btn, btn, '0, '0);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      i_reset = 1'b0;
      i_btn   = '0;
      #1;
      check("reset.level", o_btn_level, '0);
      check("reset.press", o_btn_press, '0);
      check("reset.release", o_btn_release, '0);
      repeat (2) @(posedge clock);
      #3 i_reset = 1'b1;
      @(posedge clock);
      #1;

      // Clean press then release on channel 0.
      settle("clean_press", 4'b0001, 4'b0000, 9);
      settle("clean_release", 4'b0000, 4'b0001, 9);

      // Bounce on channel 1: FSM sees every 1 aborted by the following 0.
      for (int e = 1; e <= 8; e++)
         step("bounce", (e % 2 == 1) ? 4'b0010 : 4'b0000, '0, '0, '0);
      settle("bounce_hold", 4'b0010, 4'b0000, 9);
      settle("bounce_release", 4'b0000, 4'b0010, 9);

      // Three-clock glitch on channel 2 never reaches the terminal count.
      for (int e = 1; e <= 3; e++) step("glitch", 4'b0100, '0, '0, '0);
      for (int e = 1; e <= 8; e++) step("glitch_end", 4'b0000, '0, '0, '0);

      // Long hold on channel 3, then release.
      settle("pair_press", 4'b1000, 4'b0000, 20);
      settle("pair_release", 4'b0000, 4'b1000, 10);

      // Two channels together.
      settle("simul_press", 4'b1010, 4'b0000, 9);
      settle("simul_release", 4'b0000, 4'b1010, 9);

      // Async reset while channel 0 is PRESSED, button still held afterwards.
      settle("pre_reset", 4'b0001, 4'b0000, 9);
      #2 i_reset = 1'b0;
      #1;
      check("async_reset.level", o_btn_level, '0);
      check("async_reset.press", o_btn_press, '0);
      check("async_reset.release", o_btn_release, '0);
      #2 i_reset = 1'b1;
      settle("post_reset", 4'b0001, 4'b0000, 9);
      settle("post_reset_release", 4'b0000, 4'b0001, 9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Per-button input conditioner between the board push-buttons (or the VIO button probes) and the mode and colour selection logic. Each channel has a two-flop synchronizer and a debounce state machine. A channel outputs a clean stable level, a single-cycle press pulse and a single-cycle release pulse. Consumers advance mode and colour state once per physical press instead of once per clock while the button is held.

## Interface
- NB_BTN, 4, number of independent button channels
- NB_DEBOUNCE, 20, debounce counter width; must satisfy DEBOUNCE_CYCLES-1 < 2^NB_DEBOUNCE
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); legal range 2..2^NB_DEBOUNCE

- clock  input  1  system clock; all state on rising edge
- i_reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- i_btn  input  NB_BTN  raw, asynchronous, bouncing button levels (1 = pressed)
- o_btn_level  output  NB_BTN  debounced level per channel
- o_btn_press  output  NB_BTN  one-cycle pulse when a channel's debounced level goes 0->1
- o_btn_release  output  NB_BTN  one-cycle pulse when a channel's debounced level goes 1->0

## Operation
- Channels are fully independent: separate synchronizer, counter and FSM per bit. There is no cross-channel priority.
- Synchronizer: sync1 <= i_btn[n], sync2 <= sync1. Both reset to 0. Only sync2 feeds the FSM.
- FSM states per channel: IDLE (level 0), PRESS_WAIT, PRESSED (level 1), RELEASE_WAIT.
  - IDLE: if sync2=1, go to PRESS_WAIT and set cnt<=0.
  - PRESS_WAIT:
    - if sync2=0, go to IDLE and set cnt<=0. Bounce aborts; no pulse.
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED.
    - else cnt<=cnt+1.
  - PRESSED: if sync2=0, go to RELEASE_WAIT and set cnt<=0.
  - RELEASE_WAIT:
    - if sync2=1, go back to PRESSED and set cnt<=0.
    - else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - else cnt<=cnt+1.
- Outputs are registered; no combinational path from i_btn to any output.
  - o_btn_level is 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
  - o_btn_press is high for exactly the one cycle following the PRESS_WAIT->PRESSED transition.
  - o_btn_release is high for exactly the one cycle following the RELEASE_WAIT->IDLE transition.
- The counter never wraps. It is cleared on every state entry, and the compare terminates counting at DEBOUNCE_CYCLES-1.
- o_btn_press and o_btn_release are never both high on the same channel in the same cycle. Consecutive pulses on one channel are at least DEBOUNCE_CYCLES+1 cycles apart.
- Pulses on different channels may occur in the same cycle. Consumers resolve any conflict.

## Timing
- Reset (i_reset=0): all sync flops, counters and outputs are 0 and every FSM is in IDLE immediately, without waiting for a clock edge.
- Reset mid-debounce discards the pending event. A button held through reset deassertion is treated as a new press, and its o_btn_press follows at the normal latency.
- Press latency: let edge 1 be the first rising edge that samples i_btn=1 (with setup met) for a bounce-free press.
  - o_btn_level and o_btn_press go high after edge DEBOUNCE_CYCLES+3.
  - o_btn_press falls after the next edge.
- Release latency is identical, measured from the first edge that samples i_btn=0, and applies to o_btn_level falling and o_btn_release pulsing.
- A pulse of the raw input shorter than DEBOUNCE_CYCLES+1 clocks (after synchronization) produces no output change.
- A glitch back to the old level during a wait state restarts the full DEBOUNCE_CYCLES count from zero.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NB_BTN=4.
- Clean press: i_btn=4'b0001 held from edge 1.
  - o_btn_level[0] rises after edge 7.
  - o_btn_press=4'b0001 for exactly one cycle; o_btn_release stays 0.
- Bounce rejection: i_btn[1] toggles 1,0,1,0 every clock for 8 cycles, then is held at 1.
  - No pulse occurs during the toggling.
  - A single o_btn_press[1] is asserted 7 edges after the final stable 1 is first sampled.
- Short glitch: i_btn[2]=1 for 3 clocks, then 0.
  - o_btn_level, o_btn_press and o_btn_release stay 4'b0000 throughout.
- Press/release pair: i_btn[3] is held at 1 for 20 clocks, then at 0.
  - One o_btn_press[3] occurs.
  - After release, one o_btn_release[3] occurs 7 edges after 0 is first sampled, and o_btn_level[3] returns to 0.
- Simultaneous channels: i_btn goes 4'b0000 -> 4'b1010 on the same edge.
  - o_btn_press=4'b1010 in a single cycle.
- Async reset mid-operation: assert i_reset=0 between clock edges while channel 0 is in PRESSED.
  - o_btn_level goes to 0 before the next edge.
  - With i_btn[0] still 1 after reset deasserts, o_btn_press[0] fires again 7 edges later.
